// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects, load-use stall and multi-cycle EX hold
module fwd_hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_multi,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             ex_hold,
  output logic [CNT_W-1:0] stall_cnt
);
  logic       ex_valid_q, ex_use_rs_q, ex_use_rt_q, ex_rw_q, ex_mr_q, ex_multi_q;
  logic [4:0] ex_rs_q, ex_rt_q, ex_dest_q;
  logic       mem_valid_q, mem_rw_q, mem_mr_q;
  logic [4:0] mem_dest_q;
  logic       wb_valid_q, wb_rw_q, wb_mr_q;
  logic [4:0] wb_dest_q;
  logic [3:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic       mem_wr, wb_wr, lu, id_take;
  assign mem_wr    = mem_valid_q & mem_rw_q & (mem_dest_q != 5'd0);
  assign wb_wr     = wb_valid_q & wb_rw_q & (wb_dest_q != 5'd0);
  assign ex_hold   = mc_cnt_q != 4'd0;
  assign lu        = ex_valid_q & ex_mr_q & ex_rw_q & (ex_dest_q != 5'd0) & id_valid &
                     ((id_use_rs & (id_rs == ex_dest_q)) | (id_use_rt & (id_rt == ex_dest_q)));
  assign stall     = (lu & ~flush) | ex_hold;
  assign id_take   = ~ex_hold & id_valid & ~flush & ~lu;
  assign stall_cnt = stall_cnt_q;
  // Operand selects: youngest producer (MEM) wins over WB; $0 and unread operands never forward
  always_comb begin
    fwd_a_sel = ~(ex_valid_q & ex_use_rs_q) ? 2'b00 :
                (mem_wr & (mem_dest_q == ex_rs_q)) ? 2'b10 :
                (wb_wr & (wb_dest_q == ex_rs_q)) ? 2'b01 : 2'b00;
    fwd_b_sel = ~(ex_valid_q & ex_use_rt_q) ? 2'b00 :
                (mem_wr & (mem_dest_q == ex_rt_q)) ? 2'b10 :
                (wb_wr & (wb_dest_q == ex_rt_q)) ? 2'b01 : 2'b00;
  end
  // Hold countdown is armed as a multi-cycle op enters EX; stall counter saturates
  always_comb begin
    mc_cnt_d    = ex_hold ? mc_cnt_q - 4'd1 :
                  (id_take & id_multi) ? 4'(MULT_LAT - 1) : 4'd0;
    stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  // Shadow pipeline advance: hold freezes EX and bubbles MEM, otherwise everything shifts
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= 5'd0;
      ex_rt_q     <= 5'd0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      ex_dest_q   <= 5'd0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_multi_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 5'd0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_rw_q     <= 1'b0;
      wb_mr_q     <= 1'b0;
      mc_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      wb_valid_q  <= mem_valid_q;
      wb_dest_q   <= mem_dest_q;
      wb_rw_q     <= mem_rw_q;
      wb_mr_q     <= mem_mr_q;
      if (ex_hold) begin
        mem_valid_q <= 1'b0;
      end else begin
        mem_valid_q <= ex_valid_q;
        mem_dest_q  <= ex_dest_q;
        mem_rw_q    <= ex_rw_q;
        mem_mr_q    <= ex_mr_q;
        ex_valid_q  <= id_take;
        if (id_take) begin
          ex_rs_q     <= id_rs;
          ex_rt_q     <= id_rt;
          ex_use_rs_q <= id_use_rs;
          ex_use_rt_q <= id_use_rt;
          ex_dest_q   <= id_rd;
          ex_rw_q     <= id_reg_write;
          ex_mr_q     <= id_mem_read;
          ex_multi_q  <= id_multi;
        end
      end
    end
  end
endmodule
